// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Scan scheduler for an 8-digit seven-segment scoreboard. It steps a 3-bit
// digit select every CLK_DIV cycles, blanks the segments for BLANK_CYC
// cycles at the start of each slot to stop ghosting, suppresses leading
// zeros, and commits new scores only at frame boundaries so that a frame
// never shows a mix of two scores.
//
// Optional feature: define SEG_PWM_DIM_EN to add the i_brightness input
// and a free-running 3-bit PWM dimming gate.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_score_bcd    eight BCD digits, nibble i = digit i, digit 0 rightmost
//   i_score_valid  i_score_bcd offered
//   o_score_ready  pending buffer empty, an offer will be taken
//   i_lz_blank_en  1 = suppress leading zeros
//   o_refcnt       digit select to the anode decoder
//   o_digit_bcd    nibble for the current digit
//   o_digit_on     1 = drive the segments, 0 = all segments off
//   o_frame_start  one-cycle pulse when o_refcnt enters 0 after a 7->0 wrap
//   i_brightness   PWM brightness, 7 = full on (SEG_PWM_DIM_EN only)
module seg_scan_controller #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_score_bcd,
  input  logic        i_score_valid,
  output logic        o_score_ready,
  input  logic        i_lz_blank_en,
  output logic [2:0]  o_refcnt,
  output logic [3:0]  o_digit_bcd,
  output logic        o_digit_on,
`ifdef SEG_PWM_DIM_EN
  output logic        o_frame_start,
  input  logic [2:0]  i_brightness
`else
  output logic        o_frame_start
`endif
);

  localparam int          SW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(CLK_DIV - 1);
  localparam logic [31:0] BLANK_U = 32'(BLANK_CYC);

  logic [SW-1:0] r_slot_cnt;
  logic [2:0]    r_refcnt;
  logic [31:0]   r_display;
  logic [31:0]   r_pending;
  logic          r_pend_full;
  logic          r_frame_start;

  logic          w_slot_wrap;
  logic          w_frame_wrap;
  logic          w_accept;
  logic [7:0]    w_hi_zero;
  logic          w_blanked;
  logic          w_past_blank;
  logic          w_pwm_gate;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_MAX);
  assign w_frame_wrap = w_slot_wrap && (r_refcnt == 3'd7);
  // ready is purely "pending empty"; the commit edge frees it for the next cycle
  assign w_accept     = i_score_valid && !r_pend_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot_cnt    <= '0;
      r_refcnt      <= '0;
      r_display     <= '0;
      r_pending     <= '0;
      r_pend_full   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_slot_cnt    <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_wrap) r_refcnt <= r_refcnt + 3'd1;
      r_frame_start <= w_frame_wrap;
      // Commit and accept cannot coincide: accept needs pending empty,
      // commit needs pending full. An accept on the wrap edge waits a frame.
      if (w_frame_wrap && r_pend_full) begin
        r_display   <= r_pending;
        r_pend_full <= 1'b0;
      end
      if (w_accept) begin
        r_pending   <= i_score_bcd;
        r_pend_full <= 1'b1;
      end
    end
  end

  // w_hi_zero[i]: digit i and every digit above it are zero
  assign w_hi_zero[7] = (r_display[31:28] == 4'd0);
  for (genvar i = 0; i < 7; i++) begin : g_lz
    assign w_hi_zero[i] = (r_display[4*i +: 4] == 4'd0) && w_hi_zero[i+1];
  end

  assign w_blanked    = i_lz_blank_en && (r_refcnt != 3'd0) && w_hi_zero[r_refcnt];
  assign w_past_blank = (32'(r_slot_cnt) >= BLANK_U);

`ifdef SEG_PWM_DIM_EN
  logic [2:0] r_pwm_cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pwm_cnt <= '0;
    else         r_pwm_cnt <= r_pwm_cnt + 3'd1;
  end
  // brightness is used live; a glitch only perturbs one PWM period
  assign w_pwm_gate = (r_pwm_cnt <= i_brightness);
`else
  assign w_pwm_gate = 1'b1;
`endif

  assign o_score_ready = !r_pend_full;
  assign o_refcnt      = r_refcnt;
  assign o_digit_bcd   = r_display[{r_refcnt, 2'b00} +: 4];
  assign o_digit_on    = w_past_blank && !w_blanked && w_pwm_gate;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = 8 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bcd;
  logic        valid;
  logic        ready;
  logic        lz;
  logic [2:0]  refcnt;
  logic [3:0]  digit_bcd;
  logic        digit_on;
  logic        frame_start;
`ifdef SEG_PWM_DIM_EN
  logic [2:0]  brightness;
`endif

  seg_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_score_bcd   (bcd),
    .i_score_valid (valid),
    .o_score_ready (ready),
    .i_lz_blank_en (lz),
    .o_refcnt      (refcnt),
    .o_digit_bcd   (digit_bcd),
    .o_digit_on    (digit_on),
`ifdef SEG_PWM_DIM_EN
    .o_frame_start (frame_start),
    .i_brightness  (brightness)
`else
    .o_frame_start (frame_start)
`endif
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  // Reference model: time since reset plus the score storage, all outputs
  // derived arithmetically from that.
  int          m_t;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_full;
  bit          m_fs;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int          ref_i;
    int          slot;
    bit          blank;
    bit          gate;
    logic [31:0] hi;
    ref_i = (m_t / CLK_DIV) % 8;
    slot  = m_t % CLK_DIV;
    hi    = m_disp >> (4 * ref_i);
    blank = lz && (ref_i != 0) && (hi == 32'd0);
    gate  = 1'b1;
`ifdef SEG_PWM_DIM_EN
    gate  = ((m_t % 8) <= int'(brightness));
`endif
    chk("refcnt",      32'(refcnt),      32'(ref_i));
    chk("digit_bcd",   32'(digit_bcd),   32'((m_disp >> (4 * ref_i)) & 32'hF));
    chk("digit_on",    32'(digit_on),    32'((slot >= BLANK_CYC) && !blank && gate));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("score_ready", 32'(ready),       32'(!m_full));
  endtask

  task automatic tick();
    bit wrap;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_disp = '0; m_full = 0; m_fs = 0; m_acc = 0;
    end else begin
      wrap  = (m_t % FRAME) == FRAME - 1;
      m_acc = valid && !m_full;
      m_fs  = wrap;
      if (wrap && m_full) begin
        m_disp = m_pend;
        m_full = 0;
      end
      if (m_acc) begin
        m_pend = bcd;
        m_full = 1;
      end
      m_t++;
    end
    #1;
    check_outputs();
  endtask

  task automatic offer(input logic [31:0] v);
    bcd   = v;
    valid = 1'b1;
    m_acc = 0;
    for (int n = 0; n < 4 * FRAME && !m_acc; n++) tick();
    nchk++;
    assert (m_acc) else begin
      nfail++;
      $error("FAIL offer_timeout observed=not_taken expected=taken value=%0h", v);
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bcd = '0; valid = 1'b0; lz = 1'b0;
    m_t = 0; m_disp = '0; m_pend = '0; m_full = 0; m_fs = 0; m_acc = 0;
`ifdef SEG_PWM_DIM_EN
    brightness = 3'd1;
`endif
    repeat (3) tick();
    rst = 1'b0;

    // idle scan, then a first score offered mid-frame
    repeat (5) tick();
    offer(32'h1234_5678);
    repeat (2 * FRAME) tick();

    // leading-zero suppression on and off
    lz = 1'b1;
    offer(32'h0000_0305);
    repeat (2 * FRAME) tick();
    lz = 1'b0;
    repeat (FRAME) tick();

    // all-zero score with suppression still shows digit 0
    lz = 1'b1;
    offer(32'h0000_0000);
    repeat (2 * FRAME) tick();

    // A then B held while pending full: B waits for the commit of A
    lz = 1'b0;
    offer(32'hAAAA_1111);
    offer(32'hBBBB_2222);
    repeat (2 * FRAME + 3) tick();

    // reset mid-frame with pending full: old pending never shows
    offer(32'hCAFE_F00D);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2 * FRAME) tick();

    // randomized scores, leading-zero patterns, and offers while full
    for (int k = 0; k < 24; k++) begin
      int sh;
      int idle;
      sh = $urandom_range(0, 7);
      lz = 1'($urandom_range(0, 1));
`ifdef SEG_PWM_DIM_EN
      brightness = 3'($urandom_range(0, 7));
`endif
      offer($urandom >> (4 * sh));
      idle = $urandom_range(0, 2 * FRAME);
      for (int c = 0; c < idle; c++) begin
        valid = m_full ? 1'($urandom_range(0, 1)) : 1'b0;
        bcd   = $urandom;
        tick();
      end
      valid = 1'b0;
    end
    repeat (FRAME) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
